// File: rtl/decode_ctrl_pipe_if.sv
// Handshake and control-bundle bus of the decode controller: upstream instruction
// handshake, flush, downstream bundle handshake and the mul/div busy indicator.
interface decode_ctrl_pipe_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic        out_ex_alu_src;
    logic        out_mem_write;
    logic [2:0]  out_mem_load_type;
    logic [1:0]  out_mem_store_type;
    logic        out_wb_load;
    logic        out_wb_reg_file;
    logic        out_invalid_inst;
    logic        out_muldiv;
    logic [2:0]  out_muldiv_op;
    logic        busy;

    // Pipeline side: feeds instructions, flushes, and accepts bundles.
    modport master (
        output flush, in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_ex_alu_src, out_mem_write,
               out_mem_load_type, out_mem_store_type, out_wb_load,
               out_wb_reg_file, out_invalid_inst, out_muldiv,
               out_muldiv_op, busy
    );

    modport slave (
        input  flush, in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_ex_alu_src, out_mem_write,
               out_mem_load_type, out_mem_store_type, out_wb_load,
               out_wb_reg_file, out_invalid_inst, out_muldiv,
               out_muldiv_op, busy
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered RV32IM decode controller: combinational decode into a valid/ready output
// register, with a counted busy window after each mul/div handoff that holds issue.
module decode_ctrl_pipe #(
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 33
) (
    input logic               clk,
    input logic               rst_n,
    decode_ctrl_pipe_if.slave bus
);

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_ILOAD = 7'b0000011;
    localparam logic [6:0] OP_STYPE = 7'b0100011;
    localparam logic [6:0] OP_BTYPE = 7'b1100011;
    localparam logic [6:0] OP_UTYPE = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JTYPE = 7'b1101111;
    localparam logic [6:0] OP_IJALR = 7'b1100111;

    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] LOAD_DEF = 3'd0;
    localparam logic [2:0] LOAD_LB  = 3'd1;
    localparam logic [2:0] LOAD_LH  = 3'd2;
    localparam logic [2:0] LOAD_LW  = 3'd3;
    localparam logic [2:0] LOAD_LBU = 3'd4;
    localparam logic [2:0] LOAD_LHU = 3'd5;

    localparam logic [1:0] STORE_DEF = 2'd0;
    localparam logic [1:0] STORE_SB  = 2'd1;
    localparam logic [1:0] STORE_SH  = 2'd2;
    localparam logic [1:0] STORE_SW  = 2'd3;

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef struct packed {
        logic       alu_src;
        logic       mem_write;
        logic [2:0] load_type;
        logic [1:0] store_type;
        logic       wb_load;
        logic       wb_reg_file;
        logic       invalid_inst;
        logic       muldiv;
        logic [2:0] muldiv_op;
    } bundle_t;

    typedef enum logic [0:0] {
        IDLE,
        BUSY
    } state_t;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [14:0] unused_instr_bits;

    bundle_t    dec;
    bundle_t    bundle_q, bundle_d;
    logic       vld_q, vld_d;
    state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic       busy_q;
    logic       handoff;
    logic       accept;

    assign opcode = bus.in_instr[6:0];
    assign func3  = bus.in_instr[14:12];
    assign func7  = bus.in_instr[31:25];
    assign unused_instr_bits = {bus.in_instr[24:15], bus.in_instr[11:7]};

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.wb_reg_file = 1'b1;
                if (ENABLE_M && func7 == F7_MULDIV) begin
                    dec.muldiv    = 1'b1;
                    dec.muldiv_op = func3;
                end else if (func7 != F7_ADD && func7 != F7_SUB) begin
                    dec.invalid_inst = 1'b1;
                end
            end
            OP_ITYPE: begin
                dec.alu_src     = 1'b1;
                dec.wb_reg_file = 1'b1;
            end
            OP_ILOAD: begin
                dec.alu_src     = 1'b1;
                dec.wb_reg_file = 1'b1;
                dec.wb_load     = 1'b1;
                case (func3)
                    3'd0:    dec.load_type = LOAD_LB;
                    3'd1:    dec.load_type = LOAD_LH;
                    3'd2:    dec.load_type = LOAD_LW;
                    3'd4:    dec.load_type = LOAD_LBU;
                    3'd5:    dec.load_type = LOAD_LHU;
                    default: dec.load_type = LOAD_DEF;
                endcase
            end
            OP_STYPE: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                case (func3)
                    3'd0:    dec.store_type = STORE_SB;
                    3'd1:    dec.store_type = STORE_SH;
                    3'd2:    dec.store_type = STORE_SW;
                    default: dec.store_type = STORE_DEF;
                endcase
            end
            OP_BTYPE: begin
                dec = '0;
            end
            OP_UTYPE, OP_AUIPC, OP_IJALR: begin
                dec.alu_src     = 1'b1;
                dec.wb_reg_file = 1'b1;
            end
            OP_JTYPE: begin
                dec.wb_reg_file = 1'b1;
            end
            default: begin
                dec.invalid_inst = 1'b1;
            end
        endcase
    end

    // While the mul/div unit is busy the held bundle is hidden from EX, so the
    // register can only fill (never drain) until the window closes.
    assign bus.out_valid = vld_q && (state_q == IDLE);
    assign handoff       = bus.out_valid && bus.out_ready;
    assign bus.in_ready  = !bus.flush && (!vld_q || handoff);
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        vld_d    = vld_q;
        bundle_d = bundle_q;
        if (accept) begin
            vld_d    = 1'b1;
            bundle_d = dec;
        end else if (handoff || bus.flush) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            bundle_q <= '0;
        end else begin
            vld_q    <= vld_d;
            bundle_q <= bundle_d;
        end
    end

    // Flush never touches the window: the mul/div unit has already taken the op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handoff && bundle_q.muldiv) begin
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                        cnt_q   <= bundle_q.muldiv_op[2] ? DIV_CNT : MUL_CNT;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy               = busy_q;
    assign bus.out_ex_alu_src     = bundle_q.alu_src;
    assign bus.out_mem_write      = bundle_q.mem_write;
    assign bus.out_mem_load_type  = bundle_q.load_type;
    assign bus.out_mem_store_type = bundle_q.store_type;
    assign bus.out_wb_load        = bundle_q.wb_load;
    assign bus.out_wb_reg_file    = bundle_q.wb_reg_file;
    assign bus.out_invalid_inst   = bundle_q.invalid_inst;
    assign bus.out_muldiv         = bundle_q.muldiv;
    assign bus.out_muldiv_op      = bundle_q.muldiv_op;

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Registered, handshaked decode controller for the RV32IM decode stage; successor to the combinational control decoder.
- Adds M-extension decode (MUL/DIV/REM), a parametrised multi-cycle mul/div busy window that holds issue, and a valid/ready output register with flush.
- Sits between the IF/ID register and the ID/EX register, producing per-instruction control bundles for EX/MEM/WB.

Parameters:
- ENABLE_M, 1, 1 = decode func7 7'b0000001 R-type as MUL/DIV; 0 = such encodings raise invalid.
- MUL_LAT, 2, busy cycles after a MUL* handoff (>=1).
- DIV_LAT, 33, busy cycles after a DIV*/REM* handoff (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the held instruction.
- in_valid  in  1  instruction present.
- in_ready  out  1  block accepts instruction this cycle.
- in_instr  in  32  raw instruction.
- out_valid  out  1  control bundle valid to EX.
- out_ready  in  1  EX accepts bundle.
- out_ex_alu_src  out  1  ALU operand B = immediate.
- out_mem_write  out  1  store.
- out_mem_load_type  out  3  LOAD_* code from defines.vh.
- out_mem_store_type  out  2  STORE_* code from defines.vh.
- out_wb_load  out  1  load result to WB.
- out_wb_reg_file  out  1  register-file write.
- out_invalid_inst  out  1  illegal encoding.
- out_muldiv  out  1  M-extension op.
- out_muldiv_op  out  3  func3 of the M op; 0 when out_muldiv=0.
- busy  out  1  mul/div window active.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Decode (combinational on in_instr), identical rules to the base decoder:
  - alu_src for ITYPE, ILOAD, STYPE, UTYPE, AUIPC, IJALR.
  - mem_write for STYPE. wb_load for ILOAD.
  - wb_reg_file for RTYPE, UTYPE, ITYPE, ILOAD, IJALR, AUIPC, JTYPE.
  - store func3 0/1/2 -> SB/SH/SW, else STORE_DEF. load func3 0/1/2/4/5 -> LB/HD/LW/LBU/LHU, else LOAD_DEF. Non-store/non-load -> DEF codes.
  - muldiv = ENABLE_M && opcode==RTYPE && func7==7'b0000001.
  - invalid_inst when opcode is unknown, or when RTYPE func7 is not ADD, SUB, or (ENABLE_M && 0000001).
- Output register (vld_q plus bundle): in_ready = !flush && (!vld_q || (out_valid && out_ready)). Accept = in_valid && in_ready loads the bundle and sets vld_q. A handoff without accept clears vld_q.
- Bundle is stable while out_valid && !out_ready.
- FSM states:
  - IDLE -> BUSY on handoff with out_muldiv=1; cnt loads MUL_LAT-1 if func3[2]==0, else DIV_LAT-1.
  - BUSY: cnt decrements each cycle. BUSY -> IDLE when cnt==0 at the clock edge, so busy is high for exactly LAT cycles after the handoff edge.
  - out_valid = vld_q && state==IDLE. busy = state==BUSY.
  - The register may fill during BUSY (in_ready = !flush && !vld_q); the next bundle is presented the first cycle after busy falls.
- Latency: one cycle in_valid accept -> out_valid (when IDLE). Full throughput for non-M ops.
- Flush: clears vld_q next edge and blocks accept that cycle. Does not alter FSM/cnt, because the mul/div unit is already running. Flush with simultaneous handoff: handoff completes (EX owns it), then vld_q=0.
- Reset (async assert, sync-safe release): vld_q=0, state=IDLE, cnt=0. All out_* bundle fields 0, out_valid=0, busy=0, in_ready=1 after release.
- Invalid instructions pass through with out_invalid_inst=1 and all write enables 0 apart from the decoded fields; no trap generation here.

Test Plan:
- Stream ADDI x1,x0,5 (0x00500093) then LW (0x0000A103), out_ready=1 -> out_valid cycles 1,2; alu_src=1, wb_reg_file=1; second bundle wb_load=1, load_type=LOAD_LW.
- MUL (0x022081B3), then ADD queued -> busy high 2 cycles post-handoff; ADD out_valid exactly cycle after busy falls; out_muldiv_op=0.
- DIVU (0x0220D1B3) -> busy high 33 cycles, cnt reaches 0, FSM returns to IDLE; in_ready low once the register holds the follower.
- ENABLE_M=0, MUL encoding -> out_invalid_inst=1, out_muldiv=0, busy stays 0.
- out_ready=0 for 5 cycles with SB (0x00208023) held -> bundle stable, store_type=STORE_SB, in_ready=0. Then flush -> out_valid=0 next cycle.
- Assert rst_n=0 mid-BUSY (DIV, cnt=20) -> busy=0, out_valid=0 immediately (async). After release, in_ready=1.
